// File: rtl/codec_dac_i2s_tx_if.sv
// Audio sample bus from the DAC register block into the I2S serialiser.
// The {left, right} word moves over a valid/ready handshake.
interface codec_dac_i2s_tx_if #(
  parameter int DATA_W = 16
);
  logic [2*DATA_W-1:0] audio_data;
  logic                audio_valid;
  logic                audio_ready;

  modport master (
    output audio_data,
    output audio_valid,
    input  audio_ready
  );

  modport slave (
    input  audio_data,
    input  audio_valid,
    output audio_ready
  );
endinterface

// File: rtl/codec_dac_i2s_tx.sv
// I2S transmitter for a WM8731 DAC in slave mode. It generates BCLK and DACLRCK and
// serialises {left, right} words. A holding register feeds the shift register.
module codec_dac_i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int BCLK_DIV = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  codec_dac_i2s_tx_if.slave bus,
  output logic              dac_bclk,
  output logic              dac_lrck,
  output logic              dac_dat,
  output logic              frame_start,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = $clog2(BCLK_DIV);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] BIT_RIGHT = CNT_W'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);

  logic [FRAME_W-1:0] hold_q,       hold_d;
  logic               hold_full_q,  hold_full_d;
  logic [FRAME_W-1:0] shreg_q,      shreg_d;
  logic [FRAME_W-1:0] last_frame_q, last_frame_d;
  logic [DIV_W-1:0]   div_cnt_q,    div_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
  logic               bclk_q,       bclk_d;
  logic               lrck_q,       lrck_d;
  logic               dat_q,        dat_d;
  logic               frame_start_q, frame_start_d;
  logic               underrun_q,   underrun_d;

  logic               accept_s;
  logic               tick_s;
  logic [CNT_W-1:0]   bit_next_s;

  // Next-state logic: handshake, BCLK divider, and the serialiser on each BCLK fall.
  always_comb begin
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shreg_d       = shreg_q;
    last_frame_d  = last_frame_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    bclk_d        = bclk_q;
    lrck_d        = lrck_q;
    dat_d         = dat_q;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q;

    accept_s   = bus.audio_valid & ~hold_full_q;
    tick_s     = (div_cnt_q == DIV_LAST);
    bit_next_s = (bit_cnt_q == BIT_LAST) ? {CNT_W{1'b0}} : bit_cnt_q + CNT_W'(1);

    if (accept_s) begin
      hold_d      = bus.audio_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end

    if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end

    if (!enable) begin
      div_cnt_d = {DIV_W{1'b0}};
      bit_cnt_d = BIT_LAST;
      bclk_d    = 1'b0;
      lrck_d    = 1'b0;
      dat_d     = 1'b0;
      shreg_d   = {FRAME_W{1'b0}};
    end else if (!tick_s) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end else begin
      div_cnt_d = {DIV_W{1'b0}};
      bclk_d    = ~bclk_q;
      if (bclk_q) begin
        bit_cnt_d = bit_next_s;
        dat_d     = shreg_q[FRAME_W-1];
        // Loading at the fall that drops LRCK puts the left MSB one BCLK later.
        if (bit_next_s == {CNT_W{1'b0}}) begin
          lrck_d        = 1'b0;
          frame_start_d = 1'b1;
          if (hold_full_q) begin
            shreg_d      = hold_q;
            last_frame_d = hold_q;
            hold_full_d  = 1'b0;
          end else begin
            shreg_d      = last_frame_q;
            underrun_d   = 1'b1;
          end
        end else begin
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          if (bit_next_s == BIT_RIGHT) begin
            lrck_d = 1'b1;
          end else begin
            lrck_d = lrck_q;
          end
        end
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_q        <= {FRAME_W{1'b0}};
      hold_full_q   <= 1'b0;
      shreg_q       <= {FRAME_W{1'b0}};
      last_frame_q  <= {FRAME_W{1'b0}};
      div_cnt_q     <= {DIV_W{1'b0}};
      bit_cnt_q     <= BIT_LAST;
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      dat_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shreg_q       <= shreg_d;
      last_frame_q  <= last_frame_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrck_q        <= lrck_d;
      dat_q         <= dat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bus.audio_ready = ~hold_full_q;
  assign dac_bclk        = bclk_q;
  assign dac_lrck        = lrck_q;
  assign dac_dat         = dat_q;
  assign frame_start     = frame_start_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_codec_dac_i2s_tx.sv
// Bench for codec_dac_i2s_tx: table-driven first-frame checkpoints, hand sequences, and
// randomised traffic checked every cycle against a frame-arithmetic reference model.
module tb_codec_dac_i2s_tx;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic en16 = 1'b0;
  always #5 clk = ~clk;

  codec_dac_i2s_tx_if #(.DATA_W(16)) bus ();
  codec_dac_i2s_tx_if #(.DATA_W(16)) bus16 ();
  logic bclk, lrck, dat, fs, under;
  logic bclk16, lrck16, dat16, fs16, under16;

  codec_dac_i2s_tx #(.DATA_W(16), .BCLK_DIV(D)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(en), .bus(bus),
    .dac_bclk(bclk), .dac_lrck(lrck), .dac_dat(dat), .frame_start(fs),
    .underrun(under), .underrun_clr(clr));

  codec_dac_i2s_tx #(.DATA_W(16), .BCLK_DIV(16)) dut16 (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(en16), .bus(bus16),
    .dac_bclk(bclk16), .dac_lrck(lrck16), .dac_dat(dat16), .frame_start(fs16),
    .underrun(under16), .underrun_clr(1'b0));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fs_cnt = 0;
  int fs_first = -1;
  int fs_last = -1;

  // reference model: n = run cycles since enable; falls every 2*D, frame = 32 falls
  int          n = 0;
  logic        m_full = 1'b0;
  logic [31:0] m_hold = 32'h0;
  logic [31:0] m_last = 32'h0;
  logic [31:0] m_cur = 32'h0;
  logic        m_under = 1'b0;
  logic        e_bclk = 1'b0, e_lrck = 1'b0, e_dat = 1'b0, e_fs = 1'b0;

  typedef struct {
    int   c;
    logic bclk; logic lrck; logic dat; logic fs; logic rdy; logic und;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    n = 0; m_full = 1'b0; m_hold = 32'h0; m_last = 32'h0; m_cur = 32'h0;
    m_under = 1'b0; e_bclk = 1'b0; e_lrck = 1'b0; e_dat = 1'b0; e_fs = 1'b0;
  endtask

  // one clock: advance the model from the pre-edge inputs, then compare after the edge
  task automatic step();
    logic acc;
    int f, p;
    acc  = bus.audio_valid && !m_full;
    e_fs = 1'b0;
    if (clr) m_under = 1'b0;
    if (!en) begin
      n = 0; e_bclk = 1'b0; e_lrck = 1'b0; e_dat = 1'b0; m_cur = 32'h0;
    end else begin
      n = n + 1;
      e_bclk = ((n / D) % 2) == 1;
      if ((n % (2 * D)) == 0) begin
        f = n / (2 * D);
        p = (f - 1) % 32;
        if (p == 0) begin
          e_dat = m_cur[0]; e_lrck = 1'b0; e_fs = 1'b1;
          if (m_full) begin
            m_cur = m_hold; m_last = m_hold; m_full = 1'b0;
          end else begin
            m_cur = m_last; m_under = 1'b1;
          end
        end else begin
          e_dat  = m_cur[32 - p];
          e_lrck = (p >= 16);
        end
      end
    end
    if (acc) begin
      m_hold = bus.audio_data; m_full = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("bclk", bclk, e_bclk);
    chk("lrck", lrck, e_lrck);
    chk("dat", dat, e_dat);
    chk("frame_start", fs, e_fs);
    chk("ready", bus.audio_ready, !m_full);
    chk("underrun", under, m_under);
    if (fs) begin
      fs_cnt++;
      if (fs_first < 0) fs_first = cyc;
      fs_last = cyc;
    end
  endtask

  // asynchronous reset lands between edges; outputs must clear at once
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_bclk", bclk, 1'b0);
    chk("rst_lrck", lrck, 1'b0);
    chk("rst_dat", dat, 1'b0);
    chk("rst_fs", fs, 1'b0);
    chk("rst_ready", bus.audio_ready, 1'b1);
    chk("rst_underrun", under, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int c, guard, f1, f2;
    logic accepted;
    // cycle, bclk, lrck, dat, frame_start, ready, underrun for word 24842129 at D=4
    tv[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{4,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{8,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{9,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{12,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{16,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{36,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{60,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{136, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{160, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[11] = '{263, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[12] = '{264, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[13] = '{272, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    bus.audio_valid = 1'b0; bus.audio_data = 32'h0;
    bus16.audio_valid = 1'b0; bus16.audio_data = 32'h0;
    do_reset();

    // first frame against hand-derived checkpoints
    bus.audio_valid = 1'b1; bus.audio_data = 32'h24842129;
    step();
    bus.audio_valid = 1'b0; en = 1'b1;
    c = 0;
    for (int i = 0; i < 14; i++) begin
      while (c < tv[i].c) begin step(); c++; end
      chk("tv_bclk", bclk, tv[i].bclk);
      chk("tv_lrck", lrck, tv[i].lrck);
      chk("tv_dat", dat, tv[i].dat);
      chk("tv_fs", fs, tv[i].fs);
      chk("tv_ready", bus.audio_ready, tv[i].rdy);
      chk("tv_underrun", under, tv[i].und);
    end

    // stream ten words, one accepted whenever the holding register is free
    en = 1'b0;
    do_reset();
    fs_cnt = 0; fs_first = -1; fs_last = -1;
    for (int i = 0; i < 10; i++) begin
      bus.audio_data = 32'h24842129 - 32'(i);
      bus.audio_valid = 1'b1;
      accepted = 1'b0; guard = 0;
      while (!accepted && guard < 600) begin
        accepted = !m_full;
        step();
        en = 1'b1;
        guard++;
      end
      chk("stream_accept_timeout", accepted, 1'b1);
    end
    bus.audio_valid = 1'b0;
    guard = 0;
    while (m_full && guard < 600) begin step(); guard++; end
    chk("stream_under", under, 1'b0);
    chk_int("stream_frames", fs_cnt, 10);
    chk_int("stream_span", fs_last - fs_first, 9 * 256);

    // starved: repeat and sticky underrun, clear, set again
    guard = 0;
    do begin step(); guard++; end while (!e_fs && guard < 600);
    chk("under_set", under, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("under_clr", under, 1'b0);
    guard = 0;
    do begin step(); guard++; end while (!e_fs && guard < 600);
    chk("under_reset", under, 1'b1);

    // drop enable at left bit 5 with a word waiting, then restart
    en = 1'b0;
    do_reset();
    bus.audio_valid = 1'b1; bus.audio_data = 32'hA5C30F69;
    step();
    bus.audio_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) step();
    bus.audio_valid = 1'b1; bus.audio_data = 32'h13579BDF;
    step();
    bus.audio_valid = 1'b0;
    while (n < 51) step();
    en = 1'b0;
    step();
    chk("drop_bclk", bclk, 1'b0);
    chk("drop_lrck", lrck, 1'b0);
    chk("drop_dat", dat, 1'b0);
    chk("drop_held", bus.audio_ready, 1'b0);
    step(); step();
    en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("restart_fs", fs, 1'b1);
    chk("restart_ready", bus.audio_ready, 1'b1);
    for (int i = 0; i < 300; i++) step();

    // randomised traffic; valid density alternates to provoke underruns
    for (int i = 0; i < 5000; i++) begin
      en = ($urandom_range(0, 1999) != 0);
      bus.audio_valid = ($urandom_range(0, 999) < (((i / 1000) % 2 == 1) ? 2 : 500));
      bus.audio_data = $urandom;
      clr = ($urandom_range(0, 99) == 0);
      step();
    end
    bus.audio_valid = 1'b0; clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 600; i++) step();
    chk("pre_reset_under", under, 1'b1);
    do_reset();

    // slow divider: bclk period 32, frame 1024 cycles
    en = 1'b0; en16 = 1'b1;
    c = 0; f1 = -1; f2 = -1;
    while (c < 1100) begin
      step();
      c++;
      if (c == 15) chk("div16_bclk_lo", bclk16, 1'b0);
      if (c == 16) chk("div16_bclk_hi", bclk16, 1'b1);
      if (fs16) begin
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
        chk("div16_lrck", lrck16, 1'b0);
        chk("div16_dat", dat16, 1'b0);
      end
    end
    chk_int("div16_first_fs", f1, 32);
    chk_int("div16_frame", f2 - f1, 1024);
    chk("div16_under", under16, 1'b1);
    chk("div16_ready", bus16.audio_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
